// File: rtl/ov7670_pkg.sv
// Shared encodings for the OV7670 sensor-side stream generator: pattern
// selects, FSM states and the pattern constants.
package ov7670_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      PAT_RAMP  = 2'd0,
      PAT_LINE  = 2'd1,
      PAT_BARS  = 2'd2,
      PAT_CONST = 2'd3
   } pattern_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBP    = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_VFP    = 3'd4
   } gen_state_t;

   localparam logic [7:0] CONST_BYTE = 8'h55;
   localparam logic [7:0] BAR_STEP   = 8'h20;

   // Bar 0 is white (FF); each bar to the right steps down by BAR_STEP.
   function automatic logic [7:0] bar_byte(input logic [2:0] bar);
      return 8'hFF - (BAR_STEP * {5'd0, bar});
   endfunction

endpackage

// File: rtl/ov7670_pattern_src.sv
// Combinational byte generator for the active part of a line; the caller
// forces the output to zero outside href.
module ov7670_pattern_src
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = 640
) (
   input  pattern_t         pattern,
   input  logic [CNT_W-1:0] hcnt,
   input  logic [7:0]       line_idx,
   input  logic [7:0]       ramp,
   output logic [7:0]       byte_out
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [2:0] bar;

   always_comb begin
      bar = 3'(hcnt / CNT_W'(BAR_W));
      case (pattern)
         PAT_RAMP: byte_out = ramp;
         PAT_LINE: byte_out = line_idx;
         PAT_BARS: byte_out = bar_byte(bar);
         default:  byte_out = CONST_BYTE;
      endcase
   end

endmodule

// File: rtl/ov7670_sensor_gen.sv
// OV7670 sensor emulator: drives vsync/href/d frame timing on pclk_24.
// Optional OV7670_GEN_CHECKSUM_EN adds a per-frame 16-bit byte sum output.
module ov7670_sensor_gen
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 144,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 17,
   parameter int V_ACTIVE = 240,
   parameter int V_FP     = 10
) (
   input  logic        pclk_24,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  d,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output gen_state_t  state_dbg
`ifdef OV7670_GEN_CHECKSUM_EN
   ,
   output logic [15:0] frame_checksum
`endif
);

   localparam int               H_TOTAL    = H_ACTIVE + H_BLANK;
   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   // With no front porch the frame ends on the last active line.
   localparam gen_state_t       LAST_STATE = (V_FP > 0) ? ST_VFP : ST_ACTIVE;

   gen_state_t       state, state_n;
   logic [CNT_W-1:0] hcnt, hcnt_n;
   logic [CNT_W-1:0] lcnt, lcnt_n;
   logic             line_end;
   logic             frame_end;
   logic             frame_start;

   pattern_t         pat_q;
   logic [7:0]       ramp_q;
   logic [7:0]       pat_byte;

   logic             vsync_n;
   logic             href_n;
   logic [7:0]       d_n;
   logic             frame_done_n;

   function automatic logic [CNT_W-1:0] last_line(input gen_state_t s);
      case (s)
         ST_VSYNC:  return CNT_W'(V_SYNC - 1);
         ST_VBP:    return CNT_W'(V_BP - 1);
         ST_ACTIVE: return CNT_W'(V_ACTIVE - 1);
         ST_VFP:    return CNT_W'(V_FP - 1);
         default:   return '0;
      endcase
   endfunction

   assign state_dbg = state;

   always_ff @(posedge pclk_24) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         hcnt  <= '0;
         lcnt  <= '0;
      end else begin
         state <= state_n;
         hcnt  <= hcnt_n;
         lcnt  <= lcnt_n;
      end
   end

   // enable is only looked at in IDLE and on the frame's final cycle.
   always_comb begin
      state_n     = state;
      hcnt_n      = hcnt;
      lcnt_n      = lcnt;
      frame_end   = 1'b0;
      frame_start = 1'b0;
      line_end    = (hcnt == H_LAST);
      if (state == ST_IDLE) begin
         if (enable) begin
            state_n     = ST_VSYNC;
            hcnt_n      = '0;
            lcnt_n      = '0;
            frame_start = 1'b1;
         end
      end else begin
         hcnt_n = line_end ? '0 : hcnt + CNT_W'(1);
         if (line_end) begin
            if (lcnt == last_line(state)) begin
               lcnt_n = '0;
               case (state)
                  ST_VSYNC:  state_n = (V_BP > 0) ? ST_VBP : ST_ACTIVE;
                  ST_VBP:    state_n = ST_ACTIVE;
                  ST_ACTIVE: begin
                     if (V_FP > 0) state_n = ST_VFP;
                     else          frame_end = 1'b1;
                  end
                  ST_VFP:    frame_end = 1'b1;
                  default:   state_n = ST_IDLE;
               endcase
               if (frame_end) begin
                  state_n     = enable ? ST_VSYNC : ST_IDLE;
                  frame_start = enable;
               end
            end else begin
               lcnt_n = lcnt + CNT_W'(1);
            end
         end
      end
   end

   ov7670_pattern_src #(
      .H_ACTIVE (H_ACTIVE)
   ) u_pattern_src (
      .pattern  (pat_q),
      .hcnt     (hcnt_n),
      .line_idx (lcnt_n[7:0]),
      .ramp     (ramp_q),
      .byte_out (pat_byte)
   );

   // Outputs are computed from the next state so they register alongside it.
   always_comb begin
      vsync_n      = (state_n == ST_VSYNC);
      href_n       = (state_n == ST_ACTIVE) && (hcnt_n < CNT_W'(H_ACTIVE));
      d_n          = href_n ? pat_byte : 8'h00;
      frame_done_n = (state_n == LAST_STATE) && (lcnt_n == last_line(LAST_STATE))
                     && (hcnt_n == H_LAST);
   end

   always_ff @(posedge pclk_24) begin
      if (!reset_n) begin
         vsync       <= 1'b0;
         href        <= 1'b0;
         d           <= 8'h00;
         frame_done  <= 1'b0;
         frame_count <= 16'h0000;
         pat_q       <= PAT_RAMP;
         ramp_q      <= 8'h00;
      end else begin
         vsync      <= vsync_n;
         href       <= href_n;
         d          <= d_n;
         frame_done <= frame_done_n;
         if (frame_done_n) frame_count <= frame_count + 16'd1;
         if (frame_start) begin
            pat_q  <= pattern_t'(pattern_sel);
            ramp_q <= 8'h00;
         end else if (href_n) begin
            ramp_q <= ramp_q + 8'd1;
         end
      end
   end

`ifdef OV7670_GEN_CHECKSUM_EN
   logic [15:0] csum_acc, csum_acc_n;

   assign csum_acc_n = csum_acc + {8'h00, d_n};

   always_ff @(posedge pclk_24) begin
      if (!reset_n) begin
         csum_acc       <= 16'h0000;
         frame_checksum <= 16'h0000;
      end else begin
         csum_acc <= frame_start ? 16'h0000 : csum_acc_n;
         if (frame_done_n) frame_checksum <= csum_acc_n;
      end
   end
`endif

endmodule

// File: tb/tb_ov7670_sensor_gen.sv
// Bench for ov7670_sensor_gen: directed vector table, hand-written corner
// sequences and randomized control against a frame-position reference model.
module tb_ov7670_sensor_gen;
   import ov7670_pkg::*;

   localparam int HA  = 8;
   localparam int HB  = 4;
   localparam int HT  = HA + HB;
   localparam int VS  = 2;
   localparam int VBP = 1;
   localparam int VA  = 3;
   localparam int VFP = 1;

   logic       pclk_24 = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable  = 1'b0;
   logic [1:0] pattern_sel = 2'd0;

   logic        vsync_a, href_a, fd_a, vsync_b, href_b, fd_b;
   logic [7:0]  d_a, d_b;
   logic [15:0] fc_a, fc_b;
   gen_state_t  st_a, st_b;
`ifdef OV7670_GEN_CHECKSUM_EN
   logic [15:0] cs_a, cs_b;
`endif

   always #5 pclk_24 = ~pclk_24;

   ov7670_sensor_gen #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
   ) dut_a (
      .pclk_24(pclk_24), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
      .vsync(vsync_a), .href(href_a), .d(d_a), .frame_done(fd_a),
      .frame_count(fc_a), .state_dbg(st_a)
`ifdef OV7670_GEN_CHECKSUM_EN
      , .frame_checksum(cs_a)
`endif
   );

   // Second instance with both porches removed.
   ov7670_sensor_gen #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BP(0), .V_ACTIVE(VA), .V_FP(0)
   ) dut_b (
      .pclk_24(pclk_24), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
      .vsync(vsync_b), .href(href_b), .d(d_b), .frame_done(fd_b),
      .frame_count(fc_b), .state_dbg(st_b)
`ifdef OV7670_GEN_CHECKSUM_EN
      , .frame_checksum(cs_b)
`endif
   );

   typedef struct {
      logic       vsync;
      logic       href;
      logic [7:0] d;
      logic       fd;
   } obs_t;

   typedef struct {
      int          pat;
      int          cyc;
      logic        vsync;
      logic        href;
      logic [7:0]  d;
      logic        fd;
      logic [15:0] fc;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   m_pos[2] = '{-1, -1};
   int   m_pat[2] = '{0, 0};
   int   m_cnt[2] = '{0, 0};
   int   m_sum[2] = '{0, 0};
   int   m_bp[2]  = '{VBP, 0};
   int   m_fp[2]  = '{VFP, 0};
   vec_t vecs[$];

   // Expected outputs at frame position pos (-1 = idle), from the timing rules.
   function automatic obs_t expect_at(int pos, int pat, int bp, int fp);
      obs_t o;
      int   line, h, a, total;
      o = '{vsync: 1'b0, href: 1'b0, d: 8'h00, fd: 1'b0};
      total = (VS + bp + VA + fp) * HT;
      if (pos < 0) return o;
      line    = pos / HT;
      h       = pos % HT;
      a       = line - VS - bp;
      o.vsync = (line < VS);
      o.href  = (a >= 0) && (a < VA) && (h < HA);
      if (o.href) begin
         case (pat)
            0:       o.d = 8'((a * HA + h) % 256);
            1:       o.d = 8'(a);
            2:       o.d = 8'(255 - 32 * (h / (HA / 8)));
            default: o.d = 8'h55;
         endcase
      end
      o.fd = (pos == total - 1);
      return o;
   endfunction

   function automatic int frame_total(int i);
      return (VS + m_bp[i] + VA + m_fp[i]) * HT;
   endfunction

   function automatic int frame_sum(int i, int pat);
      int   s;
      obs_t o;
      s = 0;
      for (int p = 0; p < frame_total(i); p++) begin
         o = expect_at(p, pat, m_bp[i], m_fp[i]);
         s = (s + int'(o.d)) % 65536;
      end
      return s;
   endfunction

   task automatic model_edge(input int i, input logic r, input logic e, input int p);
      if (!r) begin
         m_pos[i] = -1;
         m_cnt[i] = 0;
         m_sum[i] = 0;
      end else if (m_pos[i] < 0 || m_pos[i] == frame_total(i) - 1) begin
         if (e) begin
            m_pos[i] = 0;
            m_pat[i] = p;
         end else begin
            m_pos[i] = -1;
         end
      end else begin
         m_pos[i]++;
      end
      if (r && m_pos[i] == frame_total(i) - 1) begin
         m_cnt[i] = (m_cnt[i] + 1) % 65536;
         m_sum[i] = frame_sum(i, m_pat[i]);
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   task automatic compare_model();
      obs_t ea, eb;
      ea = expect_at(m_pos[0], m_pat[0], m_bp[0], m_fp[0]);
      eb = expect_at(m_pos[1], m_pat[1], m_bp[1], m_fp[1]);
      check("model_a", {5'd0, vsync_a, href_a, d_a, fd_a, fc_a},
            {5'd0, ea.vsync, ea.href, ea.d, ea.fd, 16'(m_cnt[0])});
      check("model_b", {5'd0, vsync_b, href_b, d_b, fd_b, fc_b},
            {5'd0, eb.vsync, eb.href, eb.d, eb.fd, 16'(m_cnt[1])});
      check("idle_state_a", 32'(st_a == ST_IDLE), 32'(m_pos[0] < 0));
`ifdef OV7670_GEN_CHECKSUM_EN
      check("checksum_a", 32'(cs_a), 32'(m_sum[0]));
      check("checksum_b", 32'(cs_b), 32'(m_sum[1]));
`endif
   endtask

   // Inputs are held across the posedge; outputs sampled on the falling edge.
   task automatic tick();
      logic r, e;
      int   p;
      r = reset_n;
      e = enable;
      p = int'(pattern_sel);
      @(posedge pclk_24);
      model_edge(0, r, e, p);
      model_edge(1, r, e, p);
      @(negedge pclk_24);
      cyc++;
      compare_model();
   endtask

   // Reset, then raise enable so the following edge is cycle 0.
   task automatic restart(input int p);
      reset_n = 1'b0;
      enable  = 1'b0;
      tick();
      reset_n     = 1'b1;
      enable      = 1'b1;
      pattern_sel = 2'(p);
      cyc = 0;
      tick();
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic add(input int p, input int c, input logic v, input logic h,
                      input logic [7:0] dd, input logic f, input logic [15:0] fc);
      vec_t x;
      x = '{pat: p, cyc: c, vsync: v, href: h, d: dd, fd: f, fc: fc};
      vecs.push_back(x);
   endtask

   initial begin
      int last_pat;
      int pa, pb;

      @(negedge pclk_24);
      tick();
      check("reset_state", 32'(st_a), 32'(ST_IDLE));
      check("reset_outs", {5'd0, vsync_a, href_a, d_a, fd_a, fc_a}, 32'd0);

      add(0,  1, 1, 0, 8'h00, 0, 0);  add(0, 24, 1, 0, 8'h00, 0, 0);
      add(0, 25, 0, 0, 8'h00, 0, 0);  add(0, 36, 0, 0, 8'h00, 0, 0);
      add(0, 37, 0, 1, 8'h00, 0, 0);  add(0, 44, 0, 1, 8'h07, 0, 0);
      add(0, 45, 0, 0, 8'h00, 0, 0);  add(0, 49, 0, 1, 8'h08, 0, 0);
      add(0, 68, 0, 1, 8'h17, 0, 0);  add(0, 83, 0, 0, 8'h00, 0, 0);
      add(0, 84, 0, 0, 8'h00, 1, 1);  add(0, 85, 1, 0, 8'h00, 0, 1);
      add(1, 37, 0, 1, 8'h00, 0, 0);  add(1, 49, 0, 1, 8'h01, 0, 0);
      add(1, 61, 0, 1, 8'h02, 0, 0);
      add(2, 37, 0, 1, 8'hFF, 0, 0);  add(2, 38, 0, 1, 8'hDF, 0, 0);
      add(2, 44, 0, 1, 8'h1F, 0, 0);  add(2, 52, 0, 1, 8'h9F, 0, 0);
      add(3, 40, 0, 1, 8'h55, 0, 0);

      last_pat = -1;
      foreach (vecs[i]) begin
         if (vecs[i].pat != last_pat || vecs[i].cyc <= cyc) restart(vecs[i].pat);
         last_pat = vecs[i].pat;
         run_to(vecs[i].cyc);
         check("vector", {5'd0, vsync_a, href_a, d_a, fd_a, fc_a},
               {5'd0, vecs[i].vsync, vecs[i].href, vecs[i].d, vecs[i].fd, vecs[i].fc});
      end

      // Porch-less instance: href right after vsync, frame ends on last active line.
      restart(0);
      run_to(24);
      check("b_vsync_end", {30'd0, vsync_b, href_b}, {30'd0, 1'b1, 1'b0});
      run_to(25);
      check("b_first_href", {22'd0, href_b, d_b, fd_b}, {22'd0, 1'b1, 8'h00, 1'b0});
      run_to(60);
      check("b_frame_done", {15'd0, fd_b, fc_b}, {15'd0, 1'b1, 16'd1});

      // Enable dropped mid-ACTIVE: frame completes, one pulse, then idle.
      restart(0);
      run_to(40);
      enable      = 1'b0;
      pattern_sel = 2'd3;
      pa = 0;
      pb = 0;
      while (cyc < 110) begin
         tick();
         pa += int'(fd_a);
         pb += int'(fd_b);
      end
      check("drop_pulses_a", 32'(pa), 32'd1);
      check("drop_pulses_b", 32'(pb), 32'd1);
      check("drop_idle_outs", {21'd0, vsync_a, href_a, d_a, fd_a}, 32'd0);
      check("drop_frame_count", 32'(fc_a), 32'd1);
      check("drop_state", 32'(st_a), 32'(ST_IDLE));

      // Pattern change mid-frame takes effect only on the next frame.
      restart(0);
      run_to(51);
      check("pat_hold_before", 32'(d_a), 32'h0A);
      pattern_sel = 2'd2;
      run_to(68);
      check("pat_hold_after", 32'(d_a), 32'h17);
      run_to(121);
      check("pat_next_frame", {23'd0, href_a, d_a}, {23'd0, 1'b1, 8'hFF});

      // Reset during ACTIVE, then re-enable.
      restart(1);
      run_to(40);
      reset_n = 1'b0;
      tick();
      check("midrst_outs", {5'd0, vsync_a, href_a, d_a, fd_a, fc_a}, 32'd0);
      check("midrst_state", 32'(st_a), 32'(ST_IDLE));
      reset_n = 1'b1;
      tick();
      check("midrst_reenable", 32'(vsync_a), 32'd1);

      // Randomized enable / pattern / occasional reset.
      enable = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         if ($urandom_range(0, 29) == 0) pattern_sel = 2'($urandom_range(0, 3));
         reset_n = ($urandom_range(0, 699) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
